// File: rtl/fifo_pkg.sv
// Shared types and helpers for the programmable FWFT FIFO family.
package fifo_pkg;

   function automatic int unsigned depth_of(input int unsigned awidth);
      return 32'd1 << awidth;
   endfunction

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
   } fifo_status_t;

endpackage

// File: rtl/fwft_fifo_ptr_cnt.sv
// Pointer, occupancy and error-flag control for the FWFT FIFO.
// The head word lives in the output register, so memory holds count-1 entries.
module fwft_fifo_ptr_cnt
   import fifo_pkg::*;
#(
   parameter int unsigned AWIDTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              write,
   input  logic              read,
   input  logic              clear_err,
   output logic              writing,
   output logic              reading,
   output logic              bypass,
   output logic [AWIDTH-1:0] wr_ptr,
   output logic [AWIDTH-1:0] rd_ptr,
   output logic [AWIDTH:0]   count,
   output logic              full,
   output logic              empty,
   output logic              overflow,
   output logic              underflow
);

   localparam int unsigned DEPTH = depth_of(AWIDTH);
   localparam int unsigned CW    = AWIDTH + 1;

   typedef logic [AWIDTH:0] cnt_t;

   cnt_t count_nxt;
   logic mem_wr;
   logic mem_rd;

   // Accept decisions and head routing: a word that would become the head
   // skips the memory and goes straight into the output register.
   always_comb begin
      writing   = write & (~full | read);
      reading   = read & ~empty;
      bypass    = writing & (empty | (reading & (count == CW'(1))));
      mem_wr    = writing & ~bypass;
      mem_rd    = reading & (count > CW'(1));
      count_nxt = count;
      if (writing & ~reading) begin
         count_nxt = count + CW'(1);
      end else if (reading & ~writing) begin
         count_nxt = count - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         full      <= 1'b0;
         empty     <= 1'b1;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (mem_wr) begin
            wr_ptr <= wr_ptr + AWIDTH'(1);
         end
         if (mem_rd) begin
            rd_ptr <= rd_ptr + AWIDTH'(1);
         end
         count     <= count_nxt;
         full      <= (count_nxt == CW'(DEPTH));
         empty     <= (count_nxt == '0);
         // A fresh error outranks a concurrent clear.
         overflow  <= (write & full & ~read) | (overflow & ~clear_err);
         underflow <= (read & empty) | (underflow & ~clear_err);
      end
   end

endmodule

// File: rtl/fwft_fifo_prog.sv
// First-word-fall-through FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module fwft_fifo_prog
   import fifo_pkg::*;
#(
   parameter int unsigned AWIDTH = 4,
   parameter int unsigned DWIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              write,
   input  logic              read,
   input  logic [DWIDTH-1:0] data_in,
   output logic [DWIDTH-1:0] data_out,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [AWIDTH:0]   count,
   input  logic [AWIDTH:0]   af_thresh,
   input  logic [AWIDTH:0]   ae_thresh,
   output logic              overflow,
   output logic              underflow,
   input  logic              clear_err
);

   localparam int unsigned DEPTH = depth_of(AWIDTH);
   localparam int unsigned CW    = AWIDTH + 1;

   logic              writing;
   logic              reading;
   logic              bypass;
   logic [AWIDTH-1:0] wr_ptr;
   logic [AWIDTH-1:0] rd_ptr;
   logic              full_r;
   logic              empty_r;
   logic [DWIDTH-1:0] mem [DEPTH];
   fifo_status_t      status;

   fwft_fifo_ptr_cnt #(
      .AWIDTH (AWIDTH)
   ) u_ptr_cnt (
      .clk       (clk),
      .rst       (rst),
      .write     (write),
      .read      (read),
      .clear_err (clear_err),
      .writing   (writing),
      .reading   (reading),
      .bypass    (bypass),
      .wr_ptr    (wr_ptr),
      .rd_ptr    (rd_ptr),
      .count     (count),
      .full      (full_r),
      .empty     (empty_r),
      .overflow  (overflow),
      .underflow (underflow)
   );

   // Entries queued behind the head.
   always_ff @(posedge clk) begin
      if (writing & ~bypass) begin
         mem[wr_ptr] <= data_in;
      end
   end

   // Head register: bypassed input, else next stored word on a pop;
   // holds its value when the last word leaves.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out <= '0;
      end else if (bypass) begin
         data_out <= data_in;
      end else if (reading & (count > CW'(1))) begin
         data_out <= mem[rd_ptr];
      end
   end

   always_comb begin
      status.full         = full_r;
      status.empty        = empty_r;
      status.almost_full  = (count >= af_thresh);
      status.almost_empty = (count <= ae_thresh);
   end

   assign full         = status.full;
   assign empty        = status.empty;
   assign almost_full  = status.almost_full;
   assign almost_empty = status.almost_empty;

endmodule

// File: tb/tb_fwft_fifo_prog.sv
// Randomised and directed bench for fwft_fifo_prog against a queue model.
module tb_fwft_fifo_prog;

   localparam int unsigned AW    = 2;
   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          write;
   logic          read;
   logic          clear_err;
   logic [DW-1:0] data_in;
   logic [DW-1:0] data_out;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic          almost_empty;
   logic [AW:0]   count;
   logic [AW:0]   af_thresh;
   logic [AW:0]   ae_thresh;
   logic          overflow;
   logic          underflow;

   int errs   = 0;
   int checks = 0;

   logic [DW-1:0] q[$];
   logic [DW-1:0] m_dout;
   bit            m_ovf;
   bit            m_unf;

   fwft_fifo_prog #(.AWIDTH(AW), .DWIDTH(DW)) dut (
      .clk          (clk),
      .rst          (rst),
      .write        (write),
      .read         (read),
      .data_in      (data_in),
      .data_out     (data_out),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .af_thresh    (af_thresh),
      .ae_thresh    (ae_thresh),
      .overflow     (overflow),
      .underflow    (underflow),
      .clear_err    (clear_err)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
   endtask

   // Drive one cycle and advance the reference model; leaves time at edge+1.
   task automatic tick(input bit w, input bit r, input logic [DW-1:0] d, input bit c);
      bit full_m;
      bit empty_m;
      write = w; read = r; data_in = d; clear_err = c;
      @(posedge clk);
      full_m  = (q.size() == DEPTH);
      empty_m = (q.size() == 0);
      m_ovf = (w && full_m && !r) || (m_ovf && !c);
      m_unf = (r && empty_m) || (m_unf && !c);
      if (r && !empty_m) void'(q.pop_front());
      if (w && (!full_m || r)) q.push_back(d);
      if (q.size() != 0) m_dout = q[0];
      #1;
      write = 1'b0; read = 1'b0; clear_err = 1'b0; data_in = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1; write = 1'b0; read = 1'b0; clear_err = 1'b0; data_in = '0;
      af_thresh = 3'd0; ae_thresh = 3'd0;
      model_reset();
      #12;
      checks++;
      if ({count, empty, full, overflow, underflow, data_out, almost_empty, almost_full}
          !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1}) begin
         errs++;
         $display("FAIL reset_state: cnt=%0d e=%b f=%b ov=%b un=%b d=%h ae=%b af=%b want 0 1 0 0 0 00 1 1",
                  count, empty, full, overflow, underflow, data_out, almost_empty, almost_full);
      end
      af_thresh = 3'd4;
      #1;
      checks++;
      if (almost_full !== 1'b0) begin
         errs++;
         $display("FAIL reset_af_thresh4: almost_full=%b want 0", almost_full);
      end
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_single();
      af_thresh = 3'd4; ae_thresh = 3'd0;
      tick(1, 0, 8'hA5, 0);
      checks++;
      if ({empty, count, data_out} !== {1'b0, 3'd1, 8'hA5}) begin
         errs++;
         $display("FAIL single_write: e=%b cnt=%0d d=%h want 0 1 a5", empty, count, data_out);
      end
      tick(0, 1, 8'h00, 0);
      checks++;
      if ({empty, count, underflow, data_out} !== {1'b1, 3'd0, 1'b0, 8'hA5}) begin
         errs++;
         $display("FAIL single_read: e=%b cnt=%0d un=%b d=%h want 1 0 0 a5", empty, count, underflow, data_out);
      end
   endtask

   task automatic test_fill_overflow();
      for (int i = 1; i <= 4; i++) tick(1, 0, 8'(i), 0);
      checks++;
      if ({full, count, data_out} !== {1'b1, 3'd4, 8'h01}) begin
         errs++;
         $display("FAIL fill_full: f=%b cnt=%0d d=%h want 1 4 01", full, count, data_out);
      end
      tick(1, 0, 8'h05, 0);
      checks++;
      if ({overflow, full, count} !== {1'b1, 1'b1, 3'd4}) begin
         errs++;
         $display("FAIL overflow_write: ov=%b f=%b cnt=%0d want 1 1 4", overflow, full, count);
      end
      for (int i = 1; i <= 4; i++) begin
         checks++;
         if (data_out !== 8'(i)) begin
            errs++;
            $display("FAIL drain_order: d=%h want %h", data_out, 8'(i));
         end
         tick(0, 1, 8'h00, 0);
      end
      checks++;
      if ({empty, count, overflow} !== {1'b1, 3'd0, 1'b1}) begin
         errs++;
         $display("FAIL drain_empty: e=%b cnt=%0d ov=%b want 1 0 1", empty, count, overflow);
      end
      tick(0, 0, 8'h00, 1);
      checks++;
      if (overflow !== 1'b0) begin
         errs++;
         $display("FAIL overflow_clear: ov=%b want 0", overflow);
      end
   endtask

   task automatic test_full_rw();
      logic [DW-1:0] exp_seq [4];
      exp_seq = '{8'h32, 8'h33, 8'h34, 8'h10};
      for (int i = 1; i <= 4; i++) tick(1, 0, 8'(8'h30 + i), 0);
      tick(1, 1, 8'h10, 0);
      checks++;
      if ({data_out, count, overflow, full} !== {8'h32, 3'd4, 1'b0, 1'b1}) begin
         errs++;
         $display("FAIL full_rw: d=%h cnt=%0d ov=%b f=%b want 32 4 0 1", data_out, count, overflow, full);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (data_out !== exp_seq[i]) begin
            errs++;
            $display("FAIL full_rw_drain: d=%h want %h", data_out, exp_seq[i]);
         end
         tick(0, 1, 8'h00, 0);
      end
   endtask

   task automatic test_back_to_back();
      tick(1, 0, 8'h00, 0);
      for (int i = 1; i < 20; i++) begin
         tick(1, 1, 8'(i), 0);
         checks++;
         if ({data_out, count, empty} !== {8'(i), 3'd1, 1'b0}) begin
            errs++;
            $display("FAIL stream_bypass: d=%h cnt=%0d e=%b want %h 1 0", data_out, count, empty, 8'(i));
         end
      end
      tick(0, 1, 8'h00, 0);
      checks++;
      if ({empty, count, data_out, underflow, overflow} !== {1'b1, 3'd0, 8'd19, 1'b0, 1'b0}) begin
         errs++;
         $display("FAIL stream_end: e=%b cnt=%0d d=%h un=%b ov=%b want 1 0 13 0 0",
                  empty, count, data_out, underflow, overflow);
      end
   endtask

   task automatic test_thresholds();
      af_thresh = 3'd3; ae_thresh = 3'd1;
      for (int n = 0; n <= 4; n++) begin
         if (n > 0) tick(1, 0, 8'(8'h40 + n), 0);
         checks++;
         if ({almost_empty, almost_full} !== {(n <= 1), (n >= 3)}) begin
            errs++;
            $display("FAIL thresh_fill n=%0d: ae=%b af=%b want %b %b", n, almost_empty, almost_full, (n <= 1), (n >= 3));
         end
      end
      af_thresh = 3'd5; ae_thresh = 3'd5;
      #1;
      checks++;
      if ({almost_full, almost_empty} !== {1'b0, 1'b1}) begin
         errs++;
         $display("FAIL thresh_above_depth: af=%b ae=%b want 0 1", almost_full, almost_empty);
      end
      af_thresh = 3'd4; ae_thresh = 3'd3;
      #1;
      checks++;
      if ({almost_full, almost_empty} !== {1'b1, 1'b0}) begin
         errs++;
         $display("FAIL thresh_equal_depth: af=%b ae=%b want 1 0", almost_full, almost_empty);
      end
      for (int i = 0; i < 4; i++) tick(0, 1, 8'h00, 0);
      tick(0, 1, 8'h00, 0);
      checks++;
      if ({underflow, count} !== {1'b1, 3'd0}) begin
         errs++;
         $display("FAIL underflow_set: un=%b cnt=%0d want 1 0", underflow, count);
      end
      tick(0, 0, 8'h00, 1);
      checks++;
      if (underflow !== 1'b0) begin
         errs++;
         $display("FAIL underflow_clear: un=%b want 0", underflow);
      end
      tick(0, 1, 8'h00, 1);
      checks++;
      if (underflow !== 1'b1) begin
         errs++;
         $display("FAIL underflow_vs_clear: un=%b want 1", underflow);
      end
      tick(0, 0, 8'h00, 1);
   endtask

   task automatic test_async_reset();
      for (int i = 1; i <= 3; i++) tick(1, 0, 8'(8'h50 + i), 0);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({count, empty, full, data_out} !== {3'd0, 1'b1, 1'b0, 8'h00}) begin
         errs++;
         $display("FAIL async_reset: cnt=%0d e=%b f=%b d=%h want 0 1 0 00", count, empty, full, data_out);
      end
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      tick(1, 0, 8'h5C, 0);
      checks++;
      if ({data_out, count, empty} !== {8'h5C, 3'd1, 1'b0}) begin
         errs++;
         $display("FAIL post_reset_write: d=%h cnt=%0d e=%b want 5c 1 0", data_out, count, empty);
      end
      tick(0, 1, 8'h00, 0);
   endtask

   task automatic test_random();
      logic [16:0] got;
      logic [16:0] exp;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (cyc % 50 == 0) begin
            af_thresh = 3'($urandom_range(0, 7));
            ae_thresh = 3'($urandom_range(0, 7));
         end
         tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 15) == 0));
         got = {count, full, empty, almost_full, almost_empty, overflow, underflow, data_out};
         exp = {3'(q.size()), (q.size() == DEPTH), (q.size() == 0),
                (q.size() >= int'(af_thresh)), (q.size() <= int'(ae_thresh)), m_ovf, m_unf, m_dout};
         checks++;
         if (got !== exp) begin
            errs++;
            $display("FAIL random cyc=%0d: {cnt,f,e,af,ae,ov,un,d}=%h want %h", cyc, got, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill_overflow();
      test_full_rw();
      test_back_to_back();
      test_thresholds();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
